// File: rtl/cache_controller_wb.sv
// Set-associative write-back / write-allocate data cache between the CPU data
// port and word-wide memory. Dirty victims are burst out before the refill burst.
module cache_controller_wb #(
  parameter int ADR_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WORD_OFFSET = 2,
  parameter int INDEX_WIDTH = 6,
  parameter int WAY_BITS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cpu2cc,
  input  logic [ADR_WIDTH-1:0]  adr_cpu2cc,
  input  logic [DATA_WIDTH-1:0] dat_cpu2cc,
  input  logic                  rdwr_cpu2cc,
  input  logic [3:0]            sel_cpu2cc,
  input  logic                  lb_cpu2cc,
  input  logic                  lbu_cpu2cc,
  input  logic                  lh_cpu2cc,
  input  logic                  lhu_cpu2cc,
  output logic                  ack_cc2cpu,
  output logic [DATA_WIDTH-1:0] dat_cc2cpu,
  output logic                  req_cc2mem,
  output logic                  we_cc2mem,
  output logic [ADR_WIDTH-1:0]  adr_cc2mem,
  output logic [DATA_WIDTH-1:0] dat_cc2mem,
  input  logic                  ack_mem2cc,
  input  logic [DATA_WIDTH-1:0] dat_mem2cc
);

  localparam int WAYS  = 1 << WAY_BITS;
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << WORD_OFFSET;
  localparam int TAG_W = ADR_WIDTH - INDEX_WIDTH - WORD_OFFSET - 2;
  localparam int WB_W  = (WAY_BITS > 0) ? WAY_BITS : 1;
  localparam logic [WORD_OFFSET-1:0] LAST = WORD_OFFSET'(WORDS - 1);
  localparam logic [WORD_OFFSET-1:0] ZERO = '0;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, GAP, REFILL, RESP} state_t;

  state_t                 state_q;
  logic                   armed_q;
  logic [ADR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]  dat_q;
  logic                   rdwr_q;
  logic [3:0]             sel_q;
  logic [3:0]             ld_q;       // {lbu, lb, lhu, lh}
  logic [WORD_OFFSET-1:0] cnt_q;
  logic [WB_W-1:0]        vic_q;
  logic [WB_W-1:0]        hit_way_q;

  logic [WB_W-1:0]        rr_q    [SETS];
  logic [WAYS-1:0]        valid_q [SETS];
  logic [WAYS-1:0]        dirty_q [SETS];
  logic [TAG_W-1:0]       tag_q   [WAYS][SETS];
  logic [DATA_WIDTH-1:0]  data_q  [WAYS][SETS][WORDS];

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]       tag;
  logic [WORD_OFFSET-1:0] word;
  logic [WORD_OFFSET-1:0] cnt_nx;
  logic [WB_W-1:0]        rr_cur, rr_nx, hit_way;
  logic                   hit;

  assign idx    = adr_q[WORD_OFFSET+2 +: INDEX_WIDTH];
  assign tag    = adr_q[ADR_WIDTH-1 -: TAG_W];
  assign word   = adr_q[2 +: WORD_OFFSET];
  assign cnt_nx = cnt_q + 1'b1;
  assign rr_cur = rr_q[idx];
  assign rr_nx  = (rr_cur == WB_W'(WAYS - 1)) ? '0 : rr_cur + 1'b1;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WB_W'(w);
      end
    end
  end

  // Big-endian lanes: byte 0 sits in bits 31:24.
  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] bo,
                                           input logic [3:0] fl);
    logic [7:0]  b;
    logic [15:0] h;
    case (bo)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = bo[1] ? w[15:0] : w[31:16];
    if (fl[3])      return {24'h0, b};
    else if (fl[2]) return {{24{b[7]}}, b};
    else if (fl[1]) return {16'h0, h};
    else if (fl[0]) return {{16{h[15]}}, h};
    else            return w;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      armed_q    <= 1'b1;
      adr_q      <= '0;
      dat_q      <= '0;
      rdwr_q     <= 1'b0;
      sel_q      <= '0;
      ld_q       <= '0;
      cnt_q      <= '0;
      vic_q      <= '0;
      hit_way_q  <= '0;
      ack_cc2cpu <= 1'b0;
      dat_cc2cpu <= '0;
      req_cc2mem <= 1'b0;
      we_cc2mem  <= 1'b0;
      adr_cc2mem <= '0;
      dat_cc2mem <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      ack_cc2cpu <= 1'b0;
      if (!req_cpu2cc) armed_q <= 1'b1;
      case (state_q)
        IDLE: if (req_cpu2cc && armed_q) begin
          adr_q   <= adr_cpu2cc;
          dat_q   <= dat_cpu2cc;
          rdwr_q  <= rdwr_cpu2cc;
          sel_q   <= sel_cpu2cc;
          ld_q    <= {lbu_cpu2cc, lb_cpu2cc, lhu_cpu2cc, lh_cpu2cc};
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            hit_way_q <= hit_way;
            state_q   <= RESP;
          end else begin
            vic_q      <= rr_cur;
            cnt_q      <= '0;
            req_cc2mem <= 1'b1;
            if (valid_q[idx][rr_cur] && dirty_q[idx][rr_cur]) begin
              we_cc2mem  <= 1'b1;
              adr_cc2mem <= {tag_q[rr_cur][idx], idx, ZERO, 2'b00};
              dat_cc2mem <= data_q[rr_cur][idx][0];
              state_q    <= WB;
            end else begin
              we_cc2mem  <= 1'b0;
              adr_cc2mem <= {tag, idx, ZERO, 2'b00};
              state_q    <= REFILL;
            end
          end
        end
        WB: if (ack_mem2cc && req_cc2mem) begin
          cnt_q <= cnt_nx;
          if (cnt_q == LAST) begin
            req_cc2mem <= 1'b0;
            we_cc2mem  <= 1'b0;
            state_q    <= GAP;
          end else begin
            adr_cc2mem <= {tag_q[vic_q][idx], idx, cnt_nx, 2'b00};
            dat_cc2mem <= data_q[vic_q][idx][cnt_nx];
          end
        end
        GAP: begin
          req_cc2mem <= 1'b1;
          we_cc2mem  <= 1'b0;
          adr_cc2mem <= {tag, idx, ZERO, 2'b00};
          cnt_q      <= '0;
          state_q    <= REFILL;
        end
        REFILL: if (ack_mem2cc && req_cc2mem) begin
          data_q[vic_q][idx][cnt_q] <= dat_mem2cc;
          cnt_q <= cnt_nx;
          if (cnt_q == LAST) begin
            // Line complete: LOOKUP re-entry is guaranteed to hit.
            tag_q[vic_q][idx]   <= tag;
            valid_q[idx][vic_q] <= 1'b1;
            dirty_q[idx][vic_q] <= 1'b0;
            rr_q[idx]           <= rr_nx;
            req_cc2mem          <= 1'b0;
            state_q             <= LOOKUP;
          end else begin
            adr_cc2mem <= {tag, idx, cnt_nx, 2'b00};
          end
        end
        RESP: begin
          ack_cc2cpu <= 1'b1;
          armed_q    <= 1'b0;
          state_q    <= IDLE;
          if (rdwr_q) begin
            dat_cc2cpu <= '0;
            for (int k = 0; k < 4; k++)
              if (sel_q[k]) data_q[hit_way_q][idx][word][8*k +: 8] <= dat_q[8*k +: 8];
            dirty_q[idx][hit_way_q] <= 1'b1;
          end else begin
            dat_cc2cpu <= load_fmt(data_q[hit_way_q][idx][word], adr_q[1:0], ld_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_controller_wb.md
Name: cache_controller_wb

Overview:
Parametrised set-associative, write-back, write-allocate data cache controller between the mor1kx CPU data port and word-wide main memory. It generalises the fixed 4-way read-refill controller in three ways: way count, set count and line length are parameters; dirty victims are written back before refill; and it supports halfword loads and byte-enabled stores. Tags, valid, dirty and data storage are internal.

Parameters:
ADR_WIDTH, 32, address width.
DATA_WIDTH, 32, word width. Fixed at 32; sub-word logic depends on it.
WORD_OFFSET, 2, log2(words per line).
INDEX_WIDTH, 6, log2(sets).
WAY_BITS, 2, log2(ways); legal range 0..3.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
req_cpu2cc  in  1  CPU request, level
adr_cpu2cc  in  ADR_WIDTH  byte address
dat_cpu2cc  in  DATA_WIDTH  store data
rdwr_cpu2cc  in  1  0=read, 1=write
sel_cpu2cc  in  4  store byte enables; sel[3]=bits 31:24
lb_cpu2cc  in  1  signed byte load
lbu_cpu2cc  in  1  unsigned byte load
lh_cpu2cc  in  1  signed halfword load
lhu_cpu2cc  in  1  unsigned halfword load
ack_cc2cpu  out  1  one-cycle completion pulse
dat_cc2cpu  out  DATA_WIDTH  load data, valid with ack
req_cc2mem  out  1  memory burst request, level
we_cc2mem  out  1  1=write-back burst, 0=refill burst
adr_cc2mem  out  ADR_WIDTH  word-aligned memory address
dat_cc2mem  out  DATA_WIDTH  write-back data
ack_mem2cc  in  1  memory accepted or delivered one word
dat_mem2cc  in  DATA_WIDTH  refill data

Behaviour:
- Address split: [1:0] byte; [WORD_OFFSET+1:2] word; next INDEX_WIDTH bits index; remaining bits tag.
- Reset (rst=0 at a clock edge):
  - All valid and dirty bits cleared; round-robin pointers set to 0; FSM goes to IDLE.
  - All outputs 0.
  - A reset mid-burst aborts the burst: req_cc2mem is 0 the next cycle, and dirty data is lost.
- FSM states: IDLE, LOOKUP, WB, GAP, REFILL, RESP.
- IDLE:
  - Accepts a request when req=1 and the armed flag is set, then latches address, data, rdwr, sel and load flags, and goes to LOOKUP.
  - armed is cleared on ack and set when req is sampled 0. A request held high after ack therefore yields exactly one ack.
- LOOKUP:
  - Compares the tag against all ways of the set.
  - Hit goes to RESP.
  - Miss selects victim = rr[index]. If victim valid&dirty go to WB, else go to REFILL.
- WB:
  - Outputs req_cc2mem=1, we=1, adr = {victim tag, index, cnt, 2'b00}, dat = victim word[cnt].
  - Each ack_mem2cc increments cnt; the new address/data appear the cycle after the ack.
  - After 2^WORD_OFFSET acks go to GAP.
- GAP: one cycle with req_cc2mem=0, then REFILL.
- REFILL:
  - Outputs req=1, we=0, adr = {req tag, index, cnt, 2'b00}, word 0 first.
  - Each ack writes dat_mem2cc into victim word[cnt].
  - After the last ack: tag written, valid=1, dirty=0, rr[index]++ (wraps), req_cc2mem=0, return to LOOKUP (guaranteed hit).
- ack_mem2cc is ignored while req_cc2mem=0.
- RESP:
  - ack_cc2cpu=1 for one cycle, then IDLE.
  - Write: bytes with sel=1 are merged into the hit word and dirty=1; dat_cc2cpu=0.
  - Read:
    - Big-endian lanes; byte 0 = bits 31:24.
    - lbu/lb: byte at adr[1:0], zero/sign extended.
    - lhu/lh: halfword at adr[1], adr[0] ignored, zero/sign extended.
    - No flag: full word.
    - Flag priority: lbu > lb > lhu > lh.
    - Load flags are ignored when rdwr=1.
- Latency:
  - Hit: ack on the 3rd edge after the request edge (IDLE→LOOKUP→RESP).
  - Clean miss adds 2^WORD_OFFSET memory acks + 1 (LOOKUP re-entry).
  - Dirty miss additionally adds the write-back acks + GAP.
- Replacement: per-set round-robin, advanced only on refill. Invalid ways are not preferred.
- dat_cc2cpu holds its value between acks.

Test Plan:
1. Cold read 0x00000104. Refill acks return 0x11111111, 0x22222222, 0x33333333, 0x44444444 → refill adr_cc2mem 0x100, 0x104, 0x108, 0x10C with we=0; no WB burst; ack with dat_cc2cpu=0x22222222.
2. Read hit 0x0000010C → ack 2 cycles after LOOKUP entry, dat=0x44444444; req_cc2mem stays 0.
3. Write 0x108, dat 0xAABBCCDD, sel 0011 → ack. Then:
   - read 0x108 → 0x3333CCDD
   - lbu 0x10B → 0x000000DD
   - lb 0x10A → 0xFFFFFFCC
   - lhu 0x108 → 0x00003333
4. Reads of 0x500, 0x900, 0xD00 fill ways 1–3. Read 0x1100 → WB burst we=1 to 0x100..0x10C with data 0x11111111, 0x22222222, 0x3333CCDD, 0x44444444; one-cycle req gap; refill 0x1100..0x110C; ack.
5. req held high 3 cycles past ack, plus repeated ack_mem2cc with req_cc2mem=0 → exactly one ack_cc2cpu, no state change.
6. rst=0 after the 2nd refill ack → req_cc2mem=0 and ack=0 next cycle; after release, read 0x104 misses (full refill burst).
